rca_pipe_addsub: RTL and testbench
==================================

// Module: rca_pipe_addsub
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the 4-bit combinational rca.
//  WIDTH-bit operands are split into STAGES equal chunks; each pipeline stage ripples one chunk
//  and registers its carry into the next stage. A valid/ready handshake sits on both sides.
//  Serves as the datapath arithmetic unit where wide adds must close timing at clk rate.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; WIDTH % STAGES == 0 required (elaboration error otherwise)
//  STAGES   4  pipeline depth = number of chunks; CHUNK = WIDTH/STAGES bits per stage; STAGES >= 1
// PORTS
//  clk        in   1      sole clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/cin/sub valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      0: add, 1: subtract
//  out_valid  out  1      s/co valid
//  out_ready  in   1      downstream accepts result
//  s          out  WIDTH  sum / difference
//  co         out  1      add: carry-out; sub: no-borrow (1 when a >= b unsigned)
// BEHAVIOUR
//  - Reset: all stage valid bits, s, co cleared to 0; in-flight operations discarded; in_ready=0 while rst=1.
//  - Arithmetic: sub=0 -> {co,s} = a + b + cin. sub=1 -> {co,s} = a + ~b + 1 (cin ignored).
//    Results are mod 2^WIDTH; co is bit WIDTH of the full sum.
//  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] with carry registered from stage k-1;
//    unprocessed upper operand bits and finished lower sum bits travel alongside in stage registers.
//  - Handshake: transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
//  - Stall: advance = out_ready || !out_valid. in_ready = advance && !rst. When advance=0 every stage
//    register holds (global stall); s/co/out_valid stable while out_valid&&!out_ready.
//  - Latency: exactly STAGES cycles from accepted input to out_valid when never stalled;
//    throughput 1 result/cycle. Results emerge in acceptance order, none dropped or duplicated.
//  - Bubbles: in_valid=0 on an advance cycle inserts an invalid slot; payload regs may update, valid=0.
//  - Simultaneous accept+emit with out_ready=1 on a full pipe: both occur same cycle, no bubble.
//  - Reset mid-operation: on the rst cycle all valids clear; first output after release is the
//    first operand accepted after release.
//  - STAGES=1: single registered ripple adder, latency 1.
// CONFIGURATION
//  ADDER_OVF_EN defined: extra output port ovf (1 bit), two's-complement signed overflow of the
//    operation (add: sign(a)==sign(b)!=sign(s); sub: sign(a)!=sign(b) && sign(s)!=sign(a)),
//    pipelined alongside s, reset 0, held under stall like s.
//  ADDER_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package/include adder_defs: CHUNK derivation, WIDTH%STAGES check macro, mode encodings
//    (MODE_ADD=1'b0, MODE_SUB=1'b1); reused by later carry-select/lookahead variants.
//  - One sub-module: rca_chunk (combinational CHUNK-bit ripple adder: x, y, ci -> sum, co),
//    instantiated STAGES times via generate; all registers live in rca_pipe_addsub.
// TESTING (WIDTH=16, STAGES=4 unless stated)
//  1. Reset: rst=1 two cycles -> out_valid=0, s=0, co=0, in_ready=0; after release in_ready=1.
//  2. Carry ripple across all chunks: a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> after 4 cycles
//     s=16'h0000, co=1; a=16'h00FF,b=16'h0001,cin=1 -> s=16'h0101, co=0.
//  3. Subtract: a=16'h0005, b=16'h0007, sub=1 -> s=16'hFFFE, co=0; a=7,b=5 -> s=2, co=1;
//     with ADDER_OVF_EN: a=16'h8000,b=1,sub=1 -> ovf=1; a=16'h7FFF,b=1,sub=0 -> ovf=1.
//  4. Back-pressure: stream 10 ops, out_ready=0 for cycles 6..9 -> in_ready=0 those cycles,
//     s/co held, all 10 results exact and in order, none lost or duplicated.
//  5. Mid-flight reset: accept 3 ops, assert rst 1 cycle -> no stale result emerges; next op
//     a=3,b=4 -> s=7 after 4 cycles.
//  6. Exhaustive small config WIDTH=4, STAGES=2: all 256 {a,b} x cin x sub with random
//     in_valid/out_ready -> every result matches reference model, latency 2 when unstalled.

Source files
------------

// File: rtl/rca_pipe_addsub_pkg.sv
// ---------------------------------------------------------------------------
// rca_pipe_addsub_pkg
// Shared definitions for the pipelined adder family (ripple, and later the
// carry-select / lookahead variants):
//   MODE_ADD / MODE_SUB : encodings of the 'sub' operation select
//   chunk_width()       : bits handled per pipeline stage
//   cfg_ok()            : legality check for a WIDTH/STAGES pairing
// No ports; imported with import rca_pipe_addsub_pkg::*.
// ---------------------------------------------------------------------------
package rca_pipe_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Each stage owns an equal slice of the operand. A degenerate stage
    // count falls back to one chunk so elaboration can still report the
    // configuration error cleanly instead of dividing by zero.
    function automatic int chunk_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    // WIDTH must split into STAGES equal, non-empty chunks.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_pipe_addsub_if.sv
// ---------------------------------------------------------------------------
// rca_pipe_addsub_if
// Handshake bundle of the pipelined adder/subtractor.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, s, co (and ovf when ADDER_OVF_EN)
// Modports:
//   master : the client that supplies operands and consumes results
//   slave  : the adder itself
// Optional feature macro: ADDER_OVF_EN adds the 1-bit signed overflow flag.
// ---------------------------------------------------------------------------
interface rca_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
`ifdef ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, s, co
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
`ifdef ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, s, co
    );

endinterface

// File: rtl/rca_pipe_addsub_chunk.sv
// ---------------------------------------------------------------------------
// rca_chunk
// Purely combinational CHUNK-bit ripple-carry adder; one instance per
// pipeline stage of rca_pipe_addsub. Holds no state.
//   x, y : CHUNK-bit operand slices
//   ci   : carry into bit 0
//   sum  : CHUNK-bit sum slice
//   co   : carry out of the top bit
// ---------------------------------------------------------------------------
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    logic [CHUNK:0] carry;

    // Classic full-adder chain; carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]     = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    end

    assign co = carry[CHUNK];

endmodule

// File: rtl/rca_pipe_addsub.sv
// ---------------------------------------------------------------------------
// rca_pipe_addsub
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit operation is cut
// into STAGES equal chunks; stage k adds chunk k and registers its carry
// for stage k+1. Latency is STAGES cycles, throughput one result per cycle.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset, clears every valid bit and s/co
//   bus : rca_pipe_addsub_if.slave
//         a, b, cin, sub, in_valid / in_ready   -> operands in
//         s, co, out_valid / out_ready          -> result out
//         sub=0: {co,s} = a + b + cin
//         sub=1: {co,s} = a + ~b + 1  (co = no-borrow, cin ignored)
// Optional feature macro: ADDER_OVF_EN drives bus.ovf with the
// two's-complement overflow of the operation, pipelined alongside s.
// ---------------------------------------------------------------------------
module rca_pipe_addsub
    import rca_pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    rca_pipe_addsub_if.slave  bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("rca_pipe_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic advance;

    // The whole pipe moves as one: it only stops when a finished result is
    // sitting at the output and nobody takes it.
    assign advance      = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = advance && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [WIDTH-1:0] s_next;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_co;

        logic [WIDTH-1:0] st_a;
        logic [WIDTH-1:0] st_b;
        logic [WIDTH-1:0] st_s;
        logic             st_c;
        logic             st_v;

        // Stage 0 folds subtraction into the operands once (invert b and
        // force the carry-in), so every later stage is a plain add. The
        // other stages take operands, partial sum and carry from the
        // registers of the stage before them.
        if (k == 0) begin : g_first
            assign a_in = bus.a;
            assign b_in = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            assign c_in = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
            assign s_in = '0;
            assign v_in = bus.in_valid;
        end else begin : g_rest
            assign a_in = g_stage[k-1].st_a;
            assign b_in = g_stage[k-1].st_b;
            assign c_in = g_stage[k-1].st_c;
            assign s_in = g_stage[k-1].st_s;
            assign v_in = g_stage[k-1].st_v;
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .x   (a_in[k*CHUNK +: CHUNK]),
            .y   (b_in[k*CHUNK +: CHUNK]),
            .ci  (c_in),
            .sum (chunk_sum),
            .co  (chunk_co)
        );

        // Lower sum bits finished by earlier stages pass through untouched;
        // this stage drops its own chunk into place.
        always_comb begin
            s_next                    = s_in;
            s_next[k*CHUNK +: CHUNK]  = chunk_sum;
        end

        // Stage register: operands still to be processed, partial sum,
        // carry into the next chunk and the slot's valid bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_v <= 1'b0;
                st_a <= '0;
                st_b <= '0;
                st_s <= '0;
                st_c <= 1'b0;
            end else if (advance) begin
                st_v <= v_in;
                st_a <= a_in;
                st_b <= b_in;
                st_s <= s_next;
                st_c <= chunk_co;
            end
        end

        // Bits already consumed by this or earlier chunks are dead from here
        // on; synthesis trims them.
        logic unused_stage;
        assign unused_stage = ^{st_a, st_b};

    end

    assign bus.out_valid = g_stage[LAST].st_v;
    assign bus.s         = g_stage[LAST].st_s;
    assign bus.co        = g_stage[LAST].st_c;

`ifdef ADDER_OVF_EN
    logic ovf_next;
    logic ovf_q;

    // With b already inverted for subtraction, both modes reduce to the
    // add rule: operands of equal sign giving a result of the other sign.
    assign ovf_next = (g_stage[LAST].a_in[WIDTH-1] == g_stage[LAST].b_in[WIDTH-1]) &&
                      (g_stage[LAST].s_next[WIDTH-1] != g_stage[LAST].a_in[WIDTH-1]);

    // Registered with the final stage so it stays aligned with s and co.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_next;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_rca_pipe_addsub
// Self-checking bench for rca_pipe_addsub: a 16-bit/4-stage instance for
// directed, back-pressure, mid-flight reset and random traffic, and a
// 4-bit/2-stage instance swept over every operand combination.
// Honours ADDER_OVF_EN when defined.
// ---------------------------------------------------------------------------
module tb_rca_pipe_addsub;

    localparam int W   = 16;
    localparam int ST  = 4;
    localparam int W4  = 4;
    localparam int ST4 = 2;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        int          acc_cycle;
        int          acc_stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rca_pipe_addsub_if #(.WIDTH(W))  bus  ();
    rca_pipe_addsub_if #(.WIDTH(W4)) bus4 ();

    rca_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rca_pipe_addsub #(.WIDTH(W4), .STAGES(ST4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    exp_t        exp_q[$];
    exp_t        exp4_q[$];
    int          checks  = 0;
    int          errors  = 0;
    int          cycle   = 0;
    int          stalls  = 0;
    int          emitted = 0;
    int          cycle4  = 0;
    int          stalls4 = 0;
    logic        stall_prev;
    logic [15:0] prev_s;
    logic        prev_co;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    // Reference arithmetic on plain integers: unsigned sum/difference with
    // the carry (or no-borrow) as bit w, and signed range overflow.
    function automatic exp_t refModel(input int w, input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic sub);
        exp_t   e;
        longint m, half, av, bv, full, sa, sb, r;
        m    = longint'(1) << w;
        half = m / 2;
        av   = longint'(a);
        bv   = longint'(b);
        full = sub ? (av - bv + m) : (av + bv + longint'(cin));
        e.s  = 16'(full % m);
        e.co = (full >= m);
        sa   = (av >= half) ? av - m : av;
        sb   = (bv >= half) ? bv - m : bv;
        r    = sub ? (sa - sb) : (sa + sb + longint'(cin));
        e.ovf = (r >= half) || (r < -half);
        e.acc_cycle  = 0;
        e.acc_stalls = 0;
        return e;
    endfunction

    // One cycle on the wide instance: drive at the falling edge, then score
    // the handshakes that the next rising edge will complete.
    task automatic applyStimulus(input logic iv, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic ordy,
                                 output logic accepted);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.out_ready = ordy;
        #1;
        cycle++;
        accepted = 1'b0;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(bus.out_ready || !bus.out_valid));
        if (stall_prev) begin
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_s", 32'(bus.s), 32'(prev_s));
            checkOutput("hold_co", 32'(bus.co), 32'(prev_co));
        end
        if (bus.out_valid && bus.out_ready) begin
            emitted++;
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("s", 32'(bus.s), 32'(e.s));
                checkOutput("co", 32'(bus.co), 32'(e.co));
`ifdef ADDER_OVF_EN
                checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                checkOutput("latency", 32'(cycle - e.acc_cycle), 32'(ST + stalls - e.acc_stalls));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e = refModel(W, a, b, cin, sub);
            e.acc_cycle  = cycle;
            e.acc_stalls = stalls;
            exp_q.push_back(e);
            accepted = 1'b1;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        if (stall_prev) stalls++;
        prev_s  = bus.s;
        prev_co = bus.co;
    endtask

    // Same cycle discipline for the narrow instance.
    task automatic applyStimulusSmall(input logic iv, input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic sub, input logic ordy,
                                      output logic accepted);
        exp_t e;
        @(negedge clk);
        bus4.in_valid  = iv;
        bus4.a         = a;
        bus4.b         = b;
        bus4.cin       = cin;
        bus4.sub       = sub;
        bus4.out_ready = ordy;
        #1;
        cycle4++;
        accepted = 1'b0;
        checkOutput("small_in_ready", 32'(bus4.in_ready), 32'(bus4.out_ready || !bus4.out_valid));
        if (bus4.out_valid && bus4.out_ready) begin
            if (exp4_q.size() == 0) begin
                checkOutput("small_spurious_out", 32'(bus4.out_valid), 32'd0);
            end else begin
                e = exp4_q.pop_front();
                checkOutput("small_s", 32'(bus4.s), 32'(e.s));
                checkOutput("small_co", 32'(bus4.co), 32'(e.co));
`ifdef ADDER_OVF_EN
                checkOutput("small_ovf", 32'(bus4.ovf), 32'(e.ovf));
`endif
                checkOutput("small_latency", 32'(cycle4 - e.acc_cycle), 32'(ST4 + stalls4 - e.acc_stalls));
            end
        end
        if (bus4.in_valid && bus4.in_ready) begin
            e = refModel(W4, {12'd0, a}, {12'd0, b}, cin, sub);
            e.acc_cycle  = cycle4;
            e.acc_stalls = stalls4;
            exp4_q.push_back(e);
            accepted = 1'b1;
        end
        if (bus4.out_valid && !bus4.out_ready) stalls4++;
    endtask

    task automatic drainMain();
        logic acc;
        for (int g = 0; g < 40 && exp_q.size() > 0; g++) begin
            applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
        end
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drainSmall();
        logic acc;
        for (int g = 0; g < 40 && exp4_q.size() > 0; g++) begin
            applyStimulusSmall(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, acc);
        end
        checkOutput("small_drain_empty", 32'(exp4_q.size()), 32'd0);
    endtask

    task automatic directedOp(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic acc;
        applyStimulus(1'b1, a, b, cin, sub, 1'b1, acc);
        checkOutput("directed_accept", 32'(acc), 32'd1);
        drainMain();
    endtask

    task automatic resetDut(input int n);
        @(negedge clk);
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_s", 32'(bus.s), 32'd0);
        checkOutput("rst_co", 32'(bus.co), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_small_out_valid", 32'(bus4.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rel_small_in_ready", 32'(bus4.in_ready), 32'd1);
        exp_q.delete();
        exp4_q.delete();
        stall_prev = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic acc;
        int   n_acc;
        int   base;

        rst            = 1'b1;
        stall_prev     = 1'b0;
        prev_s         = '0;
        prev_co        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.cin        = 1'b0;
        bus.sub        = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.cin       = 1'b0;
        bus4.sub       = 1'b0;

        $display("[TB] reset");
        resetDut(2);

        $display("[TB] directed carry ripple / subtract / overflow");
        directedOp(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        directedOp(16'h00FF, 16'h0001, 1'b1, 1'b0);
        directedOp(16'h0005, 16'h0007, 1'b0, 1'b1);
        directedOp(16'h0007, 16'h0005, 1'b1, 1'b1);
        directedOp(16'h8000, 16'h0001, 1'b0, 1'b1);
        directedOp(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        directedOp(16'h1234, 16'h1234, 1'b0, 1'b1);

        $display("[TB] back-pressure stream");
        base  = emitted;
        n_acc = 0;
        for (int c = 0; c < 24; c++) begin
            applyStimulus(n_acc < 10, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), !(c >= 6 && c <= 9), acc);
            if (acc) n_acc++;
        end
        drainMain();
        checkOutput("bp_accepted", 32'(n_acc), 32'd10);
        checkOutput("bp_emitted", 32'(emitted - base), 32'd10);

        $display("[TB] mid-flight reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, acc);
        end
        resetDut(1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
        end
        directedOp(16'd3, 16'd4, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0, acc);
        end
        drainMain();

        $display("[TB] exhaustive WIDTH=4 STAGES=2 sweep");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int idx = 0; idx < 1024; idx++) begin
            acc = 1'b0;
            for (int t = 0; t < 64 && !acc; t++) begin
                applyStimulusSmall($urandom_range(0, 3) != 0, idx[3:0], idx[7:4], idx[8], idx[9],
                                   $urandom_range(0, 3) != 0, acc);
            end
            if (!acc) checkOutput("small_accept_timeout", 32'(acc), 32'd1);
        end
        drainSmall();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
